// File: rtl/neuron_mac_fixed.sv
// Fixed-point neuron: LANES-wide multiply-accumulate over a captured input
// vector, runtime weight/bias bank, saturating rescale and selectable activation.
module neuron_mac_fixed #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_INPUTS = 16,
  parameter int LANES      = 4,
  parameter int ACTIVATION = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  weight_write,
  input  logic [$clog2(NUM_INPUTS+1)-1:0]       weight_addr,
  input  logic [DATA_WIDTH-1:0]                 weight_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out,
  output logic                                  overflow
);
  localparam int DW = DATA_WIDTH;
  localparam int G  = NUM_INPUTS / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int WA = $clog2(NUM_INPUTS + 1);
  localparam int AW = 2 * DW + $clog2(NUM_INPUTS + 1) + 1;

  localparam logic [GW-1:0] LAST = GW'(G - 1);
  localparam logic signed [AW-1:0] SMAX =
    {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic signed [DW-1:0] RMAX = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0] RMIN = ~RMAX;
  localparam logic signed [DW:0] HONE = (DW + 1)'(1) <<< FRAC_BITS;
  localparam logic signed [DW:0] HALF = HONE >>> 1;

  if (NUM_INPUTS < 2) begin : g_bad_ni
    $fatal(1, "NUM_INPUTS must be >= 2");
  end
  if (LANES < 1 || (NUM_INPUTS % LANES) != 0) begin : g_bad_lanes
    $fatal(1, "LANES must divide NUM_INPUTS");
  end
  if (FRAC_BITS < 1 || FRAC_BITS > DATA_WIDTH - 2) begin : g_bad_fb
    $fatal(1, "FRAC_BITS out of range");
  end
  if (ACTIVATION < 0 || ACTIVATION > 3) begin : g_bad_act
    $fatal(1, "ACTIVATION must be 0..3");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_SCALE, S_ACT, S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  x_q [G][LANES];
  logic signed [DW-1:0]  x_d [G][LANES];
  logic signed [DW-1:0]  w_q [G][LANES];
  logic signed [DW-1:0]  w_d [G][LANES];
  logic signed [DW-1:0]  bias_q, bias_d;
  logic signed [DW-1:0]  r_q, r_d;
  logic signed [DW-1:0]  out_q, out_d;
  logic                  ovf_q, ovf_d;

  logic                   wr_en;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   mac_sum;
  logic signed [AW-1:0]   shifted;
  logic signed [DW:0]     hs;
  logic signed [DW-1:0]   act_v;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign wr_en     = weight_write && (state_q == S_IDLE);
  assign shifted   = acc_q >>> FRAC_BITS;

  // Bank writes land on the same edge as acceptance, so bias_d is the live bias.
  always_comb begin
    w_d    = w_q;
    bias_d = bias_q;
    if (wr_en) begin
      if (weight_addr == WA'(NUM_INPUTS)) bias_d = weight_data;
      for (int g = 0; g < G; g++) begin
        for (int l = 0; l < LANES; l++) begin
          if (weight_addr == WA'(g * LANES + l)) w_d[g][l] = weight_data;
        end
      end
    end
  end

  always_comb begin
    mac_sum = '0;
    prod    = '0;
    for (int l = 0; l < LANES; l++) begin
      prod    = (2 * DW)'(x_q[grp_q][l]) * (2 * DW)'(w_q[grp_q][l]);
      mac_sum = mac_sum + AW'(prod);
    end
  end

  always_comb begin
    hs    = (DW + 1)'(r_q >>> 2) + HALF;
    act_v = r_q;
    case (ACTIVATION)
      0: act_v = r_q;
      1: if (r_q < 0) act_v = '0;
      2: if (r_q < 0) act_v = r_q >>> 3;
      default: begin
        if (hs < 0)         act_v = '0;
        else if (hs > HONE) act_v = DW'(HONE);
        else                act_v = DW'(hs);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    acc_d   = acc_q;
    x_d     = x_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int g = 0; g < G; g++) begin
            for (int l = 0; l < LANES; l++) begin
              x_d[g][l] = inputs[g * LANES + l];
            end
          end
          acc_d   = AW'(bias_d) <<< FRAC_BITS;
          grp_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + mac_sum;
        grp_d = grp_q + GW'(1);
        if (grp_q == LAST) state_d = S_SCALE;
      end
      S_SCALE: begin
        ovf_d = 1'b0;
        r_d   = shifted[DW-1:0];
        if (shifted > SMAX) begin
          r_d   = RMAX;
          ovf_d = 1'b1;
        end else if (shifted < SMIN) begin
          r_d   = RMIN;
          ovf_d = 1'b1;
        end
        state_d = S_ACT;
      end
      S_ACT: begin
        out_d   = act_v;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      acc_q   <= '0;
      x_q     <= '{default: '0};
      w_q     <= '{default: '0};
      bias_q  <= '0;
      r_q     <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      r_q     <= r_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_fixed.sv
// Bench for neuron_mac_fixed: four instances (one per activation) share
// stimulus; results checked against a table and an arithmetic reference.
module tb_neuron_mac_fixed;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NI = 4;
  localparam int LN = 2;
  localparam int WA = 3;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  weight_write = 1'b0;
  logic [WA-1:0]         weight_addr = '0;
  logic [DW-1:0]         weight_data = '0;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [NI-1:0][DW-1:0] inputs = '0;
  logic                  in_ready [4];
  logic                  out_valid [4];
  logic                  overflow [4];
  logic [DW-1:0]         o_data [4];

  always #5 clock = ~clock;

  for (genvar a = 0; a < 4; a++) begin : g_dut
    neuron_mac_fixed #(
      .DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_INPUTS(NI),
      .LANES(LN), .ACTIVATION(a)
    ) u_dut (
      .clock(clock), .reset(reset),
      .weight_write(weight_write), .weight_addr(weight_addr),
      .weight_data(weight_data),
      .in_valid(in_valid), .in_ready(in_ready[a]),
      .inputs(inputs),
      .out_valid(out_valid[a]), .out_ready(out_ready),
      .out(o_data[a]), .overflow(overflow[a])
    );
  end

  typedef struct {
    longint w;
    longint b;
    longint x [NI];
    longint e [4];
    bit     ov;
  } vec_t;

  vec_t   tab [10];
  longint mw [NI+1];
  longint xv [NI];
  int     nchk = 0;
  int     nerr = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: exact integer dot product, floor rescale, clamp, activation.
  function automatic longint ref_out(input int act, output bit ovf);
    longint s, r, t;
    s = mw[NI] * (longint'(1) << FB);
    for (int i = 0; i < NI; i++) s += xv[i] * mw[i];
    r = s >>> FB;
    ovf = 1'b0;
    if (r > 32767) begin r = 32767; ovf = 1'b1; end
    else if (r < -32768) begin r = -32768; ovf = 1'b1; end
    case (act)
      0: return r;
      1: return (r < 0) ? 0 : r;
      2: return (r < 0) ? (r >>> 3) : r;
      default: begin
        t = (r >>> 2) + 128;
        if (t < 0) t = 0;
        if (t > 256) t = 256;
        return t;
      end
    endcase
  endfunction

  task automatic model_exp(output longint e [4], output bit eo);
    for (int a = 0; a < 4; a++) e[a] = ref_out(a, eo);
  endtask

  function automatic longint rnd16(input bit full);
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    if (full) return longint'(t);
    return longint'($urandom_range(0, 2048)) - 1024;
  endfunction

  task automatic drive_x();
    for (int i = 0; i < NI; i++) inputs[i] = DW'(xv[i]);
  endtask

  task automatic write_w(input int addr, input longint data);
    @(negedge clock);
    weight_write = 1'b1;
    weight_addr  = WA'(addr);
    weight_data  = DW'(data);
    @(negedge clock);
    weight_write = 1'b0;
    if (addr <= NI) mw[addr] = data;
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic do_accept(input bit keep);
    int n = 0;
    @(negedge clock);
    drive_x();
    in_valid = 1'b1;
    while (in_ready[0] !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("accept bound", longint'(n < 30), 1);
    @(posedge clock);
    @(negedge clock);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic check_result(input string nm, input int n0,
                              input longint e [4], input bit eo);
    int n = n0;
    while (out_valid[0] !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("%s latency", nm), n, 4);
    for (int a = 0; a < 4; a++) begin
      chk($sformatf("%s out act%0d", nm, a),
          longint'($signed(o_data[a])), e[a]);
      chk($sformatf("%s ovf act%0d", nm, a), longint'(overflow[a]),
          longint'(eo));
      chk($sformatf("%s valid act%0d", nm, a), longint'(out_valid[a]), 1);
    end
  endtask

  task automatic release_out(input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      chk("hold valid", longint'(out_valid[0]), 1);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("valid one cycle", longint'(out_valid[0]), 0);
    chk("ready after out", longint'(in_ready[0]), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e [4];
    longint ea [4];
    bit     eo;
    bit     eoa;

    tab[0] = '{256, 0,   '{256, 512, -256, 768},
               '{1280, 1280, 1280, 256}, 1'b0};
    tab[1] = '{256, 128, '{-256, -256, -256, -256},
               '{-896, 0, -112, 0}, 1'b0};
    tab[2] = '{256, 128, '{256, 256, 256, 256},
               '{1152, 1152, 1152, 256}, 1'b0};
    tab[3] = '{32767, 0, '{32767, 32767, 32767, 32767},
               '{32767, 32767, 32767, 256}, 1'b1};
    tab[4] = '{32767, 0, '{-32768, -32768, -32768, -32768},
               '{-32768, 0, -4096, 0}, 1'b1};
    tab[5] = '{256, 0,   '{-2048, 0, 0, 0},
               '{-2048, 0, -256, 0}, 1'b0};
    tab[6] = '{256, 0,   '{0, 0, 0, 0},
               '{0, 0, 0, 128}, 1'b0};
    tab[7] = '{256, 0,   '{1024, 0, 0, 0},
               '{1024, 1024, 1024, 256}, 1'b0};
    tab[8] = '{256, 0,   '{-1024, 0, 0, 0},
               '{-1024, 0, -128, 0}, 1'b0};
    tab[9] = '{256, 0,   '{256, 0, 0, 0},
               '{256, 256, 256, 192}, 1'b0};
    for (int i = 0; i <= NI; i++) mw[i] = 0;

    @(negedge clock);
    for (int a = 0; a < 4; a++) begin
      chk("reset out_valid", longint'(out_valid[a]), 0);
      chk("reset out", longint'(o_data[a]), 0);
      chk("reset overflow", longint'(overflow[a]), 0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("reset in_ready", longint'(in_ready[0]), 1);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NI; i++) write_w(i, tab[t].w);
      write_w(NI, tab[t].b);
      for (int i = 0; i < NI; i++) xv[i] = tab[t].x[i];
      do_accept(1'b0);
      check_result($sformatf("tab%0d", t), 0, tab[t].e, tab[t].ov);
      release_out(0);
    end

    // Bias write in the accepting cycle feeds that same computation.
    @(negedge clock);
    xv = '{300, -700, 125, 40};
    drive_x();
    in_valid     = 1'b1;
    weight_write = 1'b1;
    weight_addr  = WA'(NI);
    weight_data  = DW'(512);
    mw[NI]       = 512;
    @(posedge clock);
    @(negedge clock);
    in_valid     = 1'b0;
    weight_write = 1'b0;
    model_exp(e, eo);
    check_result("wr_accept", 0, e, eo);
    release_out(0);

    // Backpressure with a second vector waiting.
    xv = '{32767, 32767, 32767, 32767};
    do_accept(1'b1);
    model_exp(ea, eoa);
    xv = '{100, -200, 300, -400};
    drive_x();
    check_result("bp first", 0, ea, eoa);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp out stable", longint'($signed(o_data[0])), ea[0]);
      chk("bp ovf stable", longint'(overflow[0]), longint'(eoa));
      chk("bp in_ready low", longint'(in_ready[0]), 0);
      chk("bp valid held", longint'(out_valid[0]), 1);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp ready back", longint'(in_ready[0]), 1);
    chk("bp valid drop", longint'(out_valid[0]), 0);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    model_exp(e, eo);
    check_result("bp second", 0, e, eo);
    release_out(0);

    // Writes while busy must be dropped.
    xv = '{512, 256, -128, 64};
    do_accept(1'b0);
    weight_write = 1'b1;
    weight_addr  = WA'(0);
    weight_data  = DW'(1234);
    @(negedge clock);
    weight_addr  = WA'(NI);
    weight_data  = DW'(-999);
    @(negedge clock);
    weight_write = 1'b0;
    model_exp(e, eo);
    check_result("busy write", 2, e, eo);
    release_out(0);
    xv = '{700, -300, 50, 900};
    do_accept(1'b0);
    model_exp(e, eo);
    check_result("after busy write", 0, e, eo);
    release_out(0);

    // Reset in the middle of MAC.
    xv = '{1000, 1000, 1000, 1000};
    do_accept(1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i <= NI; i++) mw[i] = 0;
    for (int a = 0; a < 4; a++) begin
      chk("midrst out_valid", longint'(out_valid[a]), 0);
      chk("midrst out", longint'(o_data[a]), 0);
      chk("midrst overflow", longint'(overflow[a]), 0);
    end
    chk("midrst in_ready", longint'(in_ready[0]), 1);
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        if (out_valid[0] === 1'b1) seen++;
      end
      chk("midrst no output", seen, 0);
    end
    xv = '{4000, -3000, 2000, 1000};
    do_accept(1'b0);
    model_exp(e, eo);
    check_result("post reset", 0, e, eo);
    chk("post reset bias-only", longint'($signed(o_data[0])), 0);
    release_out(0);

    for (int it = 0; it < 24; it++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int k = 0; k < nw; k++)
        write_w($urandom_range(0, 7), rnd16(it % 3 == 0));
      for (int i = 0; i < NI; i++) xv[i] = rnd16(it % 2 == 0);
      do_accept(1'b0);
      model_exp(e, eo);
      check_result($sformatf("rnd%0d", it), 0, e, eo);
      release_out($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
